// File: rtl/systolic_pkg.sv
// Shared constants and types for the 4x4 systolic array sequencer.
package systolic_pkg;

  localparam int N           = 4;
  localparam int FEED_CYCLES = 2 * N - 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    FEED  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } ctrl_state_t;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/systolic_4x4_ctrl_if.sv
// Host-side load/start port and array-side operand edge of the sequencer.
interface systolic_4x4_ctrl_if #(
  parameter int DW = 8
);
  logic          wr_en;
  logic          wr_sel;
  logic [1:0]    wr_row;
  logic [1:0]    wr_col;
  logic [DW-1:0] wr_data;
  logic          start;
  logic          busy;
  logic          done;
  logic          arr_clr;
  logic [DW-1:0] a1, a2, a3, a4;
  logic [DW-1:0] b1, b2, b3, b4;

  modport master (
    output wr_en, wr_sel, wr_row, wr_col, wr_data, start,
    input  busy, done, arr_clr, a1, a2, a3, a4, b1, b2, b3, b4
  );

  modport slave (
    input  wr_en, wr_sel, wr_row, wr_col, wr_data, start,
    output busy, done, arr_clr, a1, a2, a3, a4, b1, b2, b3, b4
  );
endinterface

// File: rtl/operand_buf_4x4.sv
// 16-entry operand register file, row-major {row,col} addressing, all entries visible in parallel.
module operand_buf_4x4
  import systolic_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_wr_en,
  input  logic [1:0]    i_wr_row,
  input  logic [1:0]    i_wr_col,
  input  logic [DW-1:0] i_wr_data,
  output logic [DW-1:0] o_mem [N*N]
);

  logic [3:0] w_addr;
  assign w_addr = {i_wr_row, i_wr_col};

  for (genvar gi = 0; gi < N * N; gi++) begin : g_entry
    logic [DW-1:0] r_entry;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_entry <= '0;
      end else if (i_wr_en && (w_addr == 4'(gi))) begin
        r_entry <= i_wr_data;
      end
    end

    assign o_mem[gi] = r_entry;
  end

endmodule

// File: rtl/systolic_4x4_ctrl.sv
// Sequencer for a 4x4 output-stationary systolic array: clear, skewed operand feed, drain, done.
module systolic_4x4_ctrl
  import systolic_pkg::*;
#(
  parameter int DW    = 8,
  parameter int FLUSH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  systolic_4x4_ctrl_if.slave   bus
);

  localparam logic [3:0] FEED_LAST  = 4'(FEED_CYCLES - 1);
  localparam logic [3:0] DRAIN_LAST = 4'(FLUSH - 1);

  ctrl_state_t   r_state, w_state_next;
  logic [3:0]    r_cnt, w_cnt_next;
  logic          w_wr_open, w_wr_a, w_wr_b;
  logic [DW-1:0] w_a_mem [N*N];
  logic [DW-1:0] w_b_mem [N*N];
  logic [DW-1:0] w_a [N];
  logic [DW-1:0] w_b [N];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // r_cnt is the feed step t in FEED and the remaining drain cycles in DRAIN.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    unique case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_state_next = CLEAR;
          w_cnt_next   = '0;
        end
      end
      CLEAR: begin
        w_state_next = FEED;
        w_cnt_next   = '0;
      end
      FEED: begin
        if (r_cnt == FEED_LAST) begin
          w_state_next = DRAIN;
          w_cnt_next   = DRAIN_LAST;
        end else begin
          w_cnt_next = r_cnt + 4'd1;
        end
      end
      DRAIN: begin
        if (r_cnt == 4'd0) begin
          w_state_next = DONE;
        end else begin
          w_cnt_next = r_cnt - 4'd1;
        end
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Buffers only accept writes while no run is in flight.
  assign w_wr_open = bus.wr_en && ((r_state == IDLE) || (r_state == DONE));
  assign w_wr_a    = w_wr_open && (bus.wr_sel == SEL_A);
  assign w_wr_b    = w_wr_open && (bus.wr_sel == SEL_B);

  operand_buf_4x4 #(.DW(DW)) u_buf_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_wr_en   (w_wr_a),
    .i_wr_row  (bus.wr_row),
    .i_wr_col  (bus.wr_col),
    .i_wr_data (bus.wr_data),
    .o_mem     (w_a_mem)
  );

  operand_buf_4x4 #(.DW(DW)) u_buf_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_wr_en   (w_wr_b),
    .i_wr_row  (bus.wr_row),
    .i_wr_col  (bus.wr_col),
    .i_wr_data (bus.wr_data),
    .o_mem     (w_b_mem)
  );

  // Edge gi sees operand index k = t - gi; row gi of A and column gi of B share the same window.
  for (genvar gi = 0; gi < N; gi++) begin : g_skew
    logic [3:0] w_k;
    logic       w_live;
    assign w_k    = r_cnt - 4'(gi);
    assign w_live = (r_state == FEED) && (r_cnt >= 4'(gi)) && (w_k < 4'(N));
    assign w_a[gi] = w_live ? w_a_mem[{2'(gi), w_k[1:0]}] : '0;
    assign w_b[gi] = w_live ? w_b_mem[{w_k[1:0], 2'(gi)}] : '0;
  end

  assign bus.busy    = (r_state == CLEAR) || (r_state == FEED) || (r_state == DRAIN);
  assign bus.done    = (r_state == DONE);
  assign bus.arr_clr = (r_state == CLEAR);
  assign bus.a1 = w_a[0];
  assign bus.a2 = w_a[1];
  assign bus.a3 = w_a[2];
  assign bus.a4 = w_a[3];
  assign bus.b1 = w_b[0];
  assign bus.b2 = w_b[1];
  assign bus.b3 = w_b[2];
  assign bus.b4 = w_b[3];

endmodule

// File: tb/tb_systolic_4x4_ctrl.sv
// Directed bench: drives the sequencer into a behavioural output-stationary array model and checks C.
module tb_systolic_4x4_ctrl;
  import systolic_pkg::*;

  localparam int DW    = 8;
  localparam int FLUSH = 8;
  localparam int DONE_EDGE = 8 + FLUSH;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  systolic_4x4_ctrl_if #(.DW(DW)) bus ();

  systolic_4x4_ctrl #(.DW(DW), .FLUSH(FLUSH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;

  int mA [4][4];
  int mB [4][4];
  int expC [4][4];
  int s1c [4][4] = '{'{70, 80, 90, 100}, '{96, 110, 124, 138},
                     '{122, 140, 158, 176}, '{148, 170, 192, 214}};

  logic [DW-1:0] ta [4];
  logic [DW-1:0] tbv [4];
  assign ta[0] = bus.a1;
  assign ta[1] = bus.a2;
  assign ta[2] = bus.a3;
  assign ta[3] = bus.a4;
  assign tbv[0] = bus.b1;
  assign tbv[1] = bus.b2;
  assign tbv[2] = bus.b3;
  assign tbv[3] = bus.b4;

  // Output-stationary array model: A flows right, B flows down, each PE accumulates.
  int ar [4][4];
  int br [4][4];
  int acc [4][4];

  function automatic int ain(int i, int j);
    return (j == 0) ? int'($signed(ta[i])) : ar[i][j-1];
  endfunction

  function automatic int bin(int i, int j);
    return (i == 0) ? int'($signed(tbv[j])) : br[i-1][j];
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        if (bus.arr_clr === 1'b1) begin
          acc[i][j] <= 0;
          ar[i][j]  <= 0;
          br[i][j]  <= 0;
        end else begin
          acc[i][j] <= acc[i][j] + ain(i, j) * bin(i, j);
          ar[i][j]  <= ain(i, j);
          br[i][j]  <= bin(i, j);
        end
      end
    end
  end

  function automatic logic [31:0] sx(input logic [DW-1:0] v);
    return {{(32-DW){v[DW-1]}}, v};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d (0x%h) expected %0d (0x%h)", tag, $signed(obs), obs, $signed(expv), expv);
    end
  endtask

  task automatic check_outs_zero(input string tag);
    check({tag, " busy"}, 32'(bus.busy), 32'd0);
    check({tag, " done"}, 32'(bus.done), 32'd0);
    check({tag, " arr_clr"}, 32'(bus.arr_clr), 32'd0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s a%0d", tag, i + 1), sx(ta[i]), 32'd0);
      check($sformatf("%s b%0d", tag, i + 1), sx(tbv[i]), 32'd0);
    end
  endtask

  task automatic wr(input logic sel, input int row, input int col, input int val);
    bus.wr_en   = 1'b1;
    bus.wr_sel  = sel;
    bus.wr_row  = 2'(row);
    bus.wr_col  = 2'(col);
    bus.wr_data = DW'(val);
    @(posedge clk);
    #1;
    bus.wr_en = 1'b0;
  endtask

  task automatic load_a();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) wr(SEL_A, i, j, mA[i][j]);
  endtask

  task automatic load_b();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) wr(SEL_B, i, j, mB[i][j]);
  endtask

  task automatic set_s1();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        mA[i][j]   = i + j + 1;
        mB[i][j]   = i + j + 5;
        expC[i][j] = s1c[i][j];
      end
  endtask

  task automatic check_c(input string tag);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        check($sformatf("%s C%0d%0d", tag, i + 1, j + 1), 32'(acc[i][j]), 32'(expC[i][j]));
  endtask

  // One run from the start edge E0 through E19; optionally checks the skew and injects start/write in FEED.
  task automatic run(input string tag, input bit skew, input bit inject);
    int done_cnt;
    int done_edge;
    done_cnt  = 0;
    done_edge = -1;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check({tag, " busy@E0"}, 32'(bus.busy), 32'd1);
    check({tag, " arr_clr@E0"}, 32'(bus.arr_clr), 32'd1);
    for (int k = 1; k <= 19; k++) begin
      @(posedge clk);
      #1;
      if (inject && k == 5) begin
        bus.start = 1'b0;
        bus.wr_en = 1'b0;
      end
      if (skew && k <= 7) begin
        for (int i = 0; i < 4; i++) begin
          int d;
          d = (k - 1) - i;
          check($sformatf("%s a%0d t%0d", tag, i + 1, k - 1), sx(ta[i]),
                32'((d >= 0 && d <= 3) ? mA[i][d] : 0));
          check($sformatf("%s b%0d t%0d", tag, i + 1, k - 1), sx(tbv[i]),
                32'((d >= 0 && d <= 3) ? mB[d][i] : 0));
        end
      end
      if (inject) check($sformatf("%s busy@E%0d", tag, k), 32'(bus.busy), 32'(k < DONE_EDGE));
      if (bus.done === 1'b1) begin
        done_cnt++;
        done_edge = k;
      end
      if (inject && k == 4) begin
        bus.start   = 1'b1;
        bus.wr_en   = 1'b1;
        bus.wr_sel  = SEL_A;
        bus.wr_row  = 2'd0;
        bus.wr_col  = 2'd0;
        bus.wr_data = DW'(99);
      end
    end
    check({tag, " done count"}, 32'(done_cnt), 32'd1);
    check({tag, " done edge"}, 32'(done_edge), 32'(DONE_EDGE));
  endtask

  initial begin
    int dn_edges [$];
    int pulse_long;
    logic prev_done;

    bus.wr_en = 1'b0; bus.wr_sel = 1'b0; bus.wr_row = '0; bus.wr_col = '0;
    bus.wr_data = '0; bus.start = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_outs_zero("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Scenario 1: A = i+k+1, B = k+j+5
    set_s1();
    load_a();
    load_b();
    run("s1", 1'b1, 1'b0);
    check_c("s1");

    // Identity A, B = 1..16, then negated B without reloading A
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        mA[i][j]   = (i == j) ? 1 : 0;
        mB[i][j]   = i * 4 + j + 1;
        expC[i][j] = i * 4 + j + 1;
      end
    load_a();
    load_b();
    run("ident", 1'b0, 1'b0);
    check_c("ident");
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        mB[i][j]   = -(i * 4 + j + 1);
        expC[i][j] = -(i * 4 + j + 1);
      end
    load_b();
    run("negB", 1'b1, 1'b0);
    check_c("negB");

    // Most negative operands everywhere
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        mA[i][j]   = -128;
        mB[i][j]   = -128;
        expC[i][j] = 65536;
      end
    load_a();
    load_b();
    run("m128", 1'b1, 1'b0);
    check_c("m128");

    // start and wr_en during FEED are ignored; next run sees unchanged buffers
    set_s1();
    load_a();
    load_b();
    run("inject", 1'b0, 1'b1);
    check_c("inject");
    run("after_inject", 1'b1, 1'b0);
    check_c("after_inject");

    // Reset at FEED t = 3
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_outs_zero("midrst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        mA[i][j]   = 0;
        mB[i][j]   = 0;
        expC[i][j] = 0;
      end
    run("cleared_bufs", 1'b1, 1'b0);
    check_c("cleared_bufs");
    set_s1();
    load_a();
    load_b();
    run("reload", 1'b1, 1'b0);
    check_c("reload");

    // start held high for 40 cycles
    pulse_long = 0;
    prev_done  = 1'b0;
    bus.start  = 1'b1;
    for (int n = 0; n < 60; n++) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) begin
        dn_edges.push_back(n);
        if (prev_done) pulse_long++;
      end
      prev_done = (bus.done === 1'b1);
      if (n == 39) bus.start = 1'b0;
    end
    check("held done count", 32'(dn_edges.size()), 32'd3);
    check("held pulse width", 32'(pulse_long), 32'd0);
    if (dn_edges.size() >= 1) check("held first done", 32'(dn_edges[0]), 32'(DONE_EDGE));
    for (int p = 1; p < dn_edges.size(); p++)
      check($sformatf("held period %0d", p), 32'(dn_edges[p] - dn_edges[p-1]), 32'(DONE_EDGE + 2));
    check_c("held");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
